// File: rtl/tilelink_pkg.sv
// Shared TileLink-UL constants and the beat-count helper used by the interconnect.
package tilelink_pkg;

  localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_A_ARITHMETIC_DATA  = 3'd2;
  localparam logic [2:0] TL_A_LOGICAL_DATA     = 3'd3;
  localparam logic [2:0] TL_A_GET              = 3'd4;

  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  // 4 KiB maximum message over a 4-byte bus needs up to 1024 beats.
  localparam int TL_CNT_W = 11;

  // Number of beats a data-carrying message of 2^size bytes occupies.
  function automatic logic [TL_CNT_W-1:0] beats(input int unsigned size, input int unsigned dw);
    int unsigned lg;
    lg = $clog2(dw / 8);
    if (size > lg) beats = TL_CNT_W'(32'd1 << (size - lg));
    else           beats = TL_CNT_W'(1);
  endfunction

  // Opcodes 0-3 carry data on the A channel; everything else is a single beat.
  function automatic logic tl_a_has_data(input logic [2:0] op);
    return (op <= TL_A_LOGICAL_DATA);
  endfunction

endpackage

// File: rtl/tilelink_n_to_1_if.sv
// Bus bundle for the N-to-1 interconnect: N upstream A/D ports and one downstream port.
// The "slave" modport is the interconnect's view; "master" is the surrounding environment.
interface tilelink_n_to_1_if #(
  parameter int N     = 3,
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_RS = 4,
  parameter int TL_SZ = 4
);
  localparam int MW    = $clog2(N);
  localparam int MSK_W = TL_DW / 8;
  localparam int SW    = TL_RS + MW;

  logic [N*3-1:0]     master_a_opcode;
  logic [N*3-1:0]     master_a_param;
  logic [N*TL_SZ-1:0] master_a_size;
  logic [N*TL_RS-1:0] master_a_source;
  logic [N*TL_AW-1:0] master_a_address;
  logic [N*MSK_W-1:0] master_a_mask;
  logic [N*TL_DW-1:0] master_a_data;
  logic [N-1:0]       master_a_corrupt;
  logic [N-1:0]       master_a_valid;
  logic [N-1:0]       master_a_ready;

  logic [N*3-1:0]     master_d_opcode;
  logic [N*3-1:0]     master_d_param;
  logic [N*TL_SZ-1:0] master_d_size;
  logic [N*TL_RS-1:0] master_d_source;
  logic [N-1:0]       master_d_denied;
  logic [N*TL_DW-1:0] master_d_data;
  logic [N-1:0]       master_d_corrupt;
  logic [N-1:0]       master_d_valid;
  logic [N-1:0]       master_d_ready;

  logic [2:0]         slave_a_opcode;
  logic [2:0]         slave_a_param;
  logic [TL_SZ-1:0]   slave_a_size;
  logic [SW-1:0]      slave_a_source;
  logic [TL_AW-1:0]   slave_a_address;
  logic [MSK_W-1:0]   slave_a_mask;
  logic [TL_DW-1:0]   slave_a_data;
  logic               slave_a_corrupt;
  logic               slave_a_valid;
  logic               slave_a_ready;

  logic [2:0]         slave_d_opcode;
  logic [2:0]         slave_d_param;
  logic [TL_SZ-1:0]   slave_d_size;
  logic [SW-1:0]      slave_d_source;
  logic               slave_d_denied;
  logic [TL_DW-1:0]   slave_d_data;
  logic               slave_d_corrupt;
  logic               slave_d_valid;
  logic               slave_d_ready;

  modport slave (
    input  master_a_opcode, master_a_param, master_a_size, master_a_source, master_a_address,
           master_a_mask, master_a_data, master_a_corrupt, master_a_valid,
    output master_a_ready,
    output master_d_opcode, master_d_param, master_d_size, master_d_source, master_d_denied,
           master_d_data, master_d_corrupt, master_d_valid,
    input  master_d_ready,
    output slave_a_opcode, slave_a_param, slave_a_size, slave_a_source, slave_a_address,
           slave_a_mask, slave_a_data, slave_a_corrupt, slave_a_valid,
    input  slave_a_ready,
    input  slave_d_opcode, slave_d_param, slave_d_size, slave_d_source, slave_d_denied,
           slave_d_data, slave_d_corrupt, slave_d_valid,
    output slave_d_ready
  );

  modport master (
    output master_a_opcode, master_a_param, master_a_size, master_a_source, master_a_address,
           master_a_mask, master_a_data, master_a_corrupt, master_a_valid,
    input  master_a_ready,
    input  master_d_opcode, master_d_param, master_d_size, master_d_source, master_d_denied,
           master_d_data, master_d_corrupt, master_d_valid,
    output master_d_ready,
    input  slave_a_opcode, slave_a_param, slave_a_size, slave_a_source, slave_a_address,
           slave_a_mask, slave_a_data, slave_a_corrupt, slave_a_valid,
    output slave_a_ready,
    output slave_d_opcode, slave_d_param, slave_d_size, slave_d_source, slave_d_denied,
           slave_d_data, slave_d_corrupt, slave_d_valid,
    input  slave_d_ready
  );

endinterface

// File: rtl/tl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module tl_rr_arbiter #(
  parameter int N  = 3,
  parameter int MW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [MW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [MW-1:0] o_idx,
  output logic          o_any
);

  // Scan the requests starting from the pointer; the first hit wins.
  always_comb begin : p_pick
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = MW'(j);
      end
    end
  end

endmodule

// File: rtl/tilelink_n_to_1.sv
// N-to-1 TileLink-UL interconnect: round-robin A merge with whole-message grant
// locking, stateless D return routed by the master index in the upper source bits.
//
// state    | meaning
// ST_IDLE  | no message in flight; arbiter picks a master each cycle
// ST_BURST | multi-beat A message in progress; grant locked to r_lock
module tilelink_n_to_1
  import tilelink_pkg::*;
#(
  parameter int N     = 3,
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_RS = 4,
  parameter int TL_SZ = 4
) (
  input logic               tilelink_clock_i,
  input logic               tilelink_reset_i,
  tilelink_n_to_1_if.slave  bus
);

  localparam int MW    = $clog2(N);
  localparam int MSK_W = TL_DW / 8;
  localparam int SW    = TL_RS + MW;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  function automatic logic [MW-1:0] f_next(input logic [MW-1:0] g);
    if (g == MW'(N - 1)) return '0;
    else                 return g + 1'b1;
  endfunction

  logic [0:0]          r_state;
  logic [MW-1:0]       r_ptr;
  logic [MW-1:0]       r_lock;
  logic [TL_CNT_W-1:0] r_remain;

  logic [N-1:0]        w_arb_grant;
  logic [MW-1:0]       w_arb_idx;
  logic                w_arb_any;

  logic [MW-1:0]       w_sel;
  logic                w_sel_valid;
  logic [2:0]          w_sel_opcode;
  logic [2:0]          w_sel_param;
  logic [TL_SZ-1:0]    w_sel_size;
  logic [TL_RS-1:0]    w_sel_source;
  logic [TL_AW-1:0]    w_sel_address;
  logic [MSK_W-1:0]    w_sel_mask;
  logic [TL_DW-1:0]    w_sel_data;
  logic                w_sel_corrupt;
  logic                w_out_free;
  logic                w_accept;
  logic [TL_CNT_W-1:0] w_beats;
  logic [N-1:0]        w_a_ready;

  logic [2:0]          r_a_opcode;
  logic [2:0]          r_a_param;
  logic [TL_SZ-1:0]    r_a_size;
  logic [SW-1:0]       r_a_source;
  logic [TL_AW-1:0]    r_a_address;
  logic [MSK_W-1:0]    r_a_mask;
  logic [TL_DW-1:0]    r_a_data;
  logic                r_a_corrupt;
  logic                r_a_valid;

  logic [MW-1:0]       w_d_dst;
  logic                w_d_in_range;
  logic                w_d_free;
  logic                w_d_fire;

  logic [N*3-1:0]      r_d_opcode;
  logic [N*3-1:0]      r_d_param;
  logic [N*TL_SZ-1:0]  r_d_size;
  logic [N*TL_RS-1:0]  r_d_source;
  logic [N-1:0]        r_d_denied;
  logic [N*TL_DW-1:0]  r_d_data;
  logic [N-1:0]        r_d_corrupt;
  logic [N-1:0]        r_d_valid;

  tl_rr_arbiter #(.N(N), .MW(MW)) u_arb (
    .i_req   (bus.master_a_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  assign w_sel      = (r_state == ST_BURST) ? r_lock : w_arb_idx;
  assign w_out_free = !r_a_valid || bus.slave_a_ready;
  assign w_accept   = w_out_free && w_sel_valid;
  assign w_beats    = tl_a_has_data(w_sel_opcode) ? beats(32'(w_sel_size), 32'(TL_DW))
                                                  : TL_CNT_W'(1);

  // Mux the selected master's A fields.
  always_comb begin
    w_sel_valid   = 1'b0;
    w_sel_opcode  = '0;
    w_sel_param   = '0;
    w_sel_size    = '0;
    w_sel_source  = '0;
    w_sel_address = '0;
    w_sel_mask    = '0;
    w_sel_data    = '0;
    w_sel_corrupt = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_sel == MW'(i)) begin
        w_sel_valid   = bus.master_a_valid[i];
        w_sel_opcode  = bus.master_a_opcode[i*3 +: 3];
        w_sel_param   = bus.master_a_param[i*3 +: 3];
        w_sel_size    = bus.master_a_size[i*TL_SZ +: TL_SZ];
        w_sel_source  = bus.master_a_source[i*TL_RS +: TL_RS];
        w_sel_address = bus.master_a_address[i*TL_AW +: TL_AW];
        w_sel_mask    = bus.master_a_mask[i*MSK_W +: MSK_W];
        w_sel_data    = bus.master_a_data[i*TL_DW +: TL_DW];
        w_sel_corrupt = bus.master_a_corrupt[i];
      end
    end
  end

  // Only the granted (or locked) master sees ready, and only when the output slot frees.
  always_comb begin
    w_a_ready = '0;
    if (w_out_free) begin
      if (r_state == ST_BURST) begin
        for (int i = 0; i < N; i++) w_a_ready[i] = (r_lock == MW'(i));
      end else begin
        w_a_ready = w_arb_grant;
      end
    end
  end

  assign bus.master_a_ready = w_a_ready;

  // Grant FSM: lock for multi-beat messages, advance pointer when a message completes.
  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
    if (!tilelink_reset_i) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_lock   <= '0;
      r_remain <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_beats > TL_CNT_W'(1)) begin
              r_state  <= ST_BURST;
              r_lock   <= w_sel;
              r_remain <= w_beats - TL_CNT_W'(1);
            end else begin
              r_ptr <= f_next(w_sel);
            end
          end
        end
        ST_BURST: begin
          if (w_accept) begin
            r_remain <= r_remain - TL_CNT_W'(1);
            if (r_remain == TL_CNT_W'(1)) begin
              r_state <= ST_IDLE;
              r_ptr   <= f_next(r_lock);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Slave A output register; fields hold while valid is stalled.
  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
    if (!tilelink_reset_i) begin
      r_a_valid   <= 1'b0;
      r_a_opcode  <= '0;
      r_a_param   <= '0;
      r_a_size    <= '0;
      r_a_source  <= '0;
      r_a_address <= '0;
      r_a_mask    <= '0;
      r_a_data    <= '0;
      r_a_corrupt <= 1'b0;
    end else if (w_accept) begin
      r_a_valid   <= 1'b1;
      r_a_opcode  <= w_sel_opcode;
      r_a_param   <= w_sel_param;
      r_a_size    <= w_sel_size;
      r_a_source  <= {w_sel, w_sel_source};
      r_a_address <= w_sel_address;
      r_a_mask    <= w_sel_mask;
      r_a_data    <= w_sel_data;
      r_a_corrupt <= w_sel_corrupt;
    end else if (bus.slave_a_ready) begin
      r_a_valid <= 1'b0;
    end
  end

  assign bus.slave_a_valid   = r_a_valid;
  assign bus.slave_a_opcode  = r_a_opcode;
  assign bus.slave_a_param   = r_a_param;
  assign bus.slave_a_size    = r_a_size;
  assign bus.slave_a_source  = r_a_source;
  assign bus.slave_a_address = r_a_address;
  assign bus.slave_a_mask    = r_a_mask;
  assign bus.slave_a_data    = r_a_data;
  assign bus.slave_a_corrupt = r_a_corrupt;

  assign w_d_dst = bus.slave_d_source[SW-1:TL_RS];

  // Ready follows the destination register; unknown destinations are drained.
  always_comb begin
    w_d_in_range = 1'b0;
    w_d_free     = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (w_d_dst == MW'(i)) begin
        w_d_in_range = 1'b1;
        w_d_free     = !r_d_valid[i] || bus.master_d_ready[i];
      end
    end
  end

  assign bus.slave_d_ready = w_d_free;
  assign w_d_fire          = bus.slave_d_valid && w_d_free && w_d_in_range;

  // Per-master D output registers.
  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
    if (!tilelink_reset_i) begin
      r_d_valid   <= '0;
      r_d_opcode  <= '0;
      r_d_param   <= '0;
      r_d_size    <= '0;
      r_d_source  <= '0;
      r_d_denied  <= '0;
      r_d_data    <= '0;
      r_d_corrupt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_d_fire && (w_d_dst == MW'(i))) begin
          r_d_valid[i]                  <= 1'b1;
          r_d_opcode[i*3 +: 3]          <= bus.slave_d_opcode;
          r_d_param[i*3 +: 3]           <= bus.slave_d_param;
          r_d_size[i*TL_SZ +: TL_SZ]    <= bus.slave_d_size;
          r_d_source[i*TL_RS +: TL_RS]  <= bus.slave_d_source[TL_RS-1:0];
          r_d_denied[i]                 <= bus.slave_d_denied;
          r_d_data[i*TL_DW +: TL_DW]    <= bus.slave_d_data;
          r_d_corrupt[i]                <= bus.slave_d_corrupt;
        end else if (bus.master_d_ready[i]) begin
          r_d_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.master_d_valid   = r_d_valid;
  assign bus.master_d_opcode  = r_d_opcode;
  assign bus.master_d_param   = r_d_param;
  assign bus.master_d_size    = r_d_size;
  assign bus.master_d_source  = r_d_source;
  assign bus.master_d_denied  = r_d_denied;
  assign bus.master_d_data    = r_d_data;
  assign bus.master_d_corrupt = r_d_corrupt;

endmodule

// File: tb/tb_tilelink_n_to_1.sv
// Directed bench for tilelink_n_to_1 (N=3, 32-bit data, 4-bit master source).
module tb_tilelink_n_to_1;
  import tilelink_pkg::*;

  localparam int N = 3;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  tilelink_n_to_1_if #(.N(N), .TL_DW(32), .TL_AW(32), .TL_RS(4), .TL_SZ(4)) bus ();

  tilelink_n_to_1 #(.N(N), .TL_DW(32), .TL_AW(32), .TL_RS(4), .TL_SZ(4)) dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst_n),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] valid;
    logic       sar;
    logic [2:0] exp_rdy;
    logic       exp_sav;
    logic [5:0] exp_src;
  } arb_vec_t;

  arb_vec_t vecs [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{3'b111, 1'b1, 3'b001, 1'b1, 6'h08};
    vecs[1]  = '{3'b111, 1'b1, 3'b010, 1'b1, 6'h19};
    vecs[2]  = '{3'b111, 1'b1, 3'b100, 1'b1, 6'h2A};
    vecs[3]  = '{3'b111, 1'b1, 3'b001, 1'b1, 6'h08};
    vecs[4]  = '{3'b111, 1'b1, 3'b010, 1'b1, 6'h19};
    vecs[5]  = '{3'b111, 1'b1, 3'b100, 1'b1, 6'h2A};
    vecs[6]  = '{3'b110, 1'b1, 3'b010, 1'b1, 6'h19};
    vecs[7]  = '{3'b011, 1'b1, 3'b001, 1'b1, 6'h08};
    vecs[8]  = '{3'b100, 1'b0, 3'b000, 1'b1, 6'h08};
    vecs[9]  = '{3'b100, 1'b1, 3'b100, 1'b1, 6'h2A};
    vecs[10] = '{3'b000, 1'b1, 3'b000, 1'b0, 6'h2A};
    vecs[11] = '{3'b000, 1'b0, 3'b000, 1'b0, 6'h2A};
    vecs[12] = '{3'b101, 1'b0, 3'b001, 1'b1, 6'h08};
    vecs[13] = '{3'b101, 1'b0, 3'b000, 1'b1, 6'h08};
    vecs[14] = '{3'b101, 1'b1, 3'b100, 1'b1, 6'h2A};

    rst_n                = 1'b0;
    bus.master_a_opcode  = '0;
    bus.master_a_param   = '0;
    bus.master_a_size    = '0;
    bus.master_a_source  = '0;
    bus.master_a_address = '0;
    bus.master_a_mask    = '0;
    bus.master_a_data    = '0;
    bus.master_a_corrupt = '0;
    bus.master_a_valid   = '0;
    bus.master_d_ready   = 3'b111;
    bus.slave_a_ready    = 1'b1;
    bus.slave_d_opcode   = '0;
    bus.slave_d_param    = '0;
    bus.slave_d_size     = '0;
    bus.slave_d_source   = '0;
    bus.slave_d_denied   = 1'b0;
    bus.slave_d_data     = '0;
    bus.slave_d_corrupt  = 1'b0;
    bus.slave_d_valid    = 1'b0;

    // Reset state and idle after release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sav", 64'(bus.slave_a_valid), 64'd0);
    chk("rst_mdv", 64'(bus.master_d_valid), 64'd0);
    chk("rst_src", 64'(bus.slave_a_source), 64'd0);
    chk("rst_adata", 64'(bus.slave_a_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_sav", 64'(bus.slave_a_valid), 64'd0);
      chk("idle_mdv", 64'(bus.master_d_valid), 64'd0);
    end

    // First Get from master 1: size 2, source 3.
    bus.master_a_opcode = {TL_A_GET, TL_A_GET, TL_A_GET};
    bus.master_a_size   = {4'd2, 4'd2, 4'd2};
    bus.master_a_source = {4'hA, 4'h3, 4'h8};
    bus.master_a_valid  = 3'b010;
    #1;
    chk("first_rdy", 64'(bus.master_a_ready), 64'h2);
    tick();
    bus.master_a_valid = 3'b000;
    chk("first_sav", 64'(bus.slave_a_valid), 64'd1);
    chk("first_src", 64'(bus.slave_a_source), 64'h13);
    chk("first_op", 64'(bus.slave_a_opcode), 64'(TL_A_GET));
    chk("first_size", 64'(bus.slave_a_size), 64'd2);
    tick();
    chk("first_clear", 64'(bus.slave_a_valid), 64'd0);

    // Fresh reset so the pointer starts at 0 for the arbitration table.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.master_a_source = {4'hA, 4'h9, 4'h8};
    for (int i = 0; i < 15; i++) begin
      bus.master_a_valid = vecs[i].valid;
      bus.slave_a_ready  = vecs[i].sar;
      #1;
      chk($sformatf("arb_rdy[%0d]", i), 64'(bus.master_a_ready), 64'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("arb_sav[%0d]", i), 64'(bus.slave_a_valid), 64'(vecs[i].exp_sav));
      chk($sformatf("arb_src[%0d]", i), 64'(bus.slave_a_source), 64'(vecs[i].exp_src));
    end

    // Master 0 PutFullData size 4 (4 beats) while master 2 waits; pointer is 0 here.
    bus.slave_a_ready   = 1'b1;
    bus.master_a_opcode = {TL_A_GET, TL_A_GET, TL_A_PUT_FULL_DATA};
    bus.master_a_size   = {4'd2, 4'd2, 4'd4};
    bus.master_a_source = {4'hA, 4'h9, 4'h1};
    bus.master_a_valid  = 3'b101;
    for (int b = 0; b < 4; b++) begin
      bus.master_a_data = {32'hEE, 32'h0, 32'hD0 + 32'(b)};
      #1;
      chk($sformatf("burst_rdy[%0d]", b), 64'(bus.master_a_ready), 64'h1);
      tick();
      chk($sformatf("burst_sav[%0d]", b), 64'(bus.slave_a_valid), 64'd1);
      chk($sformatf("burst_src[%0d]", b), 64'(bus.slave_a_source), 64'h01);
      chk($sformatf("burst_data[%0d]", b), 64'(bus.slave_a_data), 64'hD0 + 64'(b));
    end
    chk("burst_op", 64'(bus.slave_a_opcode), 64'(TL_A_PUT_FULL_DATA));
    bus.master_a_valid = 3'b100;
    #1;
    chk("after_burst_rdy", 64'(bus.master_a_ready), 64'h4);
    tick();
    chk("after_burst_src", 64'(bus.slave_a_source), 64'h2A);
    chk("after_burst_data", 64'(bus.slave_a_data), 64'hEE);
    bus.master_a_valid = 3'b000;
    tick();

    // AccessAckData size 3, source 0x25: two beats to master 2 with source 5.
    bus.slave_d_opcode = TL_D_ACCESS_ACK_DATA;
    bus.slave_d_size   = 4'd3;
    bus.slave_d_source = 6'h25;
    bus.slave_d_valid  = 1'b1;
    for (int b = 0; b < 2; b++) begin
      bus.slave_d_data = 32'hA0 + 32'(b);
      #1;
      chk($sformatf("d_sdr[%0d]", b), 64'(bus.slave_d_ready), 64'd1);
      tick();
      chk($sformatf("d_mdv[%0d]", b), 64'(bus.master_d_valid), 64'h4);
      chk($sformatf("d_src[%0d]", b), 64'(bus.master_d_source[11:8]), 64'h5);
      chk($sformatf("d_data[%0d]", b), 64'(bus.master_d_data[95:64]), 64'hA0 + 64'(b));
      chk($sformatf("d_op[%0d]", b), 64'(bus.master_d_opcode[8:6]), 64'(TL_D_ACCESS_ACK_DATA));
    end
    bus.slave_d_valid = 1'b0;
    tick();
    chk("d_drain", 64'(bus.master_d_valid), 64'd0);

    // Master 1 stalls on D; a beat for master 0 still passes.
    bus.master_d_ready = 3'b101;
    bus.slave_d_source = 6'h17;
    bus.slave_d_data   = 32'h11;
    bus.slave_d_valid  = 1'b1;
    #1;
    chk("stall_sdr_a", 64'(bus.slave_d_ready), 64'd1);
    tick();
    chk("stall_mdv_a", 64'(bus.master_d_valid), 64'h2);
    bus.slave_d_source = 6'h16;
    bus.slave_d_data   = 32'h22;
    #1;
    chk("stall_sdr_b", 64'(bus.slave_d_ready), 64'd0);
    tick();
    chk("stall_mdv_b", 64'(bus.master_d_valid), 64'h2);
    chk("stall_hold_data", 64'(bus.master_d_data[63:32]), 64'h11);
    chk("stall_hold_src", 64'(bus.master_d_source[7:4]), 64'h7);
    bus.slave_d_source = 6'h03;
    bus.slave_d_data   = 32'h33;
    #1;
    chk("stall_sdr_c", 64'(bus.slave_d_ready), 64'd1);
    tick();
    chk("stall_mdv_c", 64'(bus.master_d_valid), 64'h3);
    chk("stall_m0_data", 64'(bus.master_d_data[31:0]), 64'h33);
    chk("stall_m1_data", 64'(bus.master_d_data[63:32]), 64'h11);
    bus.slave_d_source = 6'h31;
    bus.slave_d_data   = 32'h44;
    #1;
    chk("oor_sdr", 64'(bus.slave_d_ready), 64'd1);
    tick();
    chk("oor_mdv", 64'(bus.master_d_valid), 64'h2);
    bus.slave_d_valid  = 1'b0;
    bus.master_d_ready = 3'b111;
    tick();
    chk("stall_release", 64'(bus.master_d_valid), 64'd0);

    // Reset during beat 2 of a 4-beat burst, with a D beat pending to master 1.
    bus.master_d_ready = 3'b101;
    bus.slave_d_source = 6'h12;
    bus.slave_d_valid  = 1'b1;
    tick();
    bus.slave_d_valid = 1'b0;
    chk("mid_pending_d", 64'(bus.master_d_valid), 64'h2);
    bus.master_a_valid = 3'b001;
    tick();
    tick();
    bus.master_a_valid = 3'b111;
    #1;
    chk("mid_locked_rdy", 64'(bus.master_a_ready), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sav", 64'(bus.slave_a_valid), 64'd0);
    chk("mid_rst_mdv", 64'(bus.master_d_valid), 64'd0);
    chk("mid_rst_data", 64'(bus.slave_a_data), 64'd0);
    bus.master_a_valid = 3'b110;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", 64'(bus.master_a_ready), 64'h2);
    tick();
    chk("post_rst_sav", 64'(bus.slave_a_valid), 64'd1);
    chk("post_rst_src", 64'(bus.slave_a_source), 64'h19);
    bus.master_a_valid = 3'b000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
